// File: rtl/knn_result_reader_if.sv
// Result stream from knn_result_reader toward the host-side wrapper.
// master drives the beat, slave drives m_ready.
interface knn_result_reader_if #(
    parameter int dataWidth = 32,
    parameter int k         = 3
);
    localparam int IW = (k > 1) ? $clog2(k) : 1;

    logic                 m_valid;
    logic                 m_ready;
    logic [31:0]          m_name;
    logic [dataWidth-1:0] m_value;
    logic [IW-1:0]        m_index;
    logic                 m_last;

    modport master (
        output m_valid,
        output m_name,
        output m_value,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_name,
        input  m_value,
        input  m_index,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/knn_result_reader.sv
// Drains k (name, value) results from the KNN accelerator after done and
// replays them, in read order, as a valid/ready stream.
module knn_result_reader #(
    parameter int dataWidth   = 32,
    parameter int k           = 3,
    parameter int readLatency = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 done,
    output logic                 rd_en,
    input  logic [31:0]          dataNameIn,
    input  logic [dataWidth-1:0] dataValueIn,
    knn_result_reader_if.master  result,
    output logic                 busy,
    output logic                 complete
);
    localparam int CW = $clog2(k + 1);
    localparam int IW = (k > 1) ? $clog2(k) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic                   armed;
    logic [CW-1:0]          issue_cnt;
    logic [CW-1:0]          cap_cnt;
    logic [IW-1:0]          cap_idx;
    logic [IW-1:0]          ptr;
    logic [readLatency-1:0] strobe_pipe;
    logic [31:0]            buf_name  [k];
    logic [dataWidth-1:0]   buf_value [k];

    logic cap_hit;
    logic cap_last;
    logic xfer;
    logic xfer_last;

    always_comb begin
        state_nx       = state;
        rd_en          = 1'b0;
        cap_hit        = 1'b0;
        cap_last       = 1'b0;
        xfer           = 1'b0;
        xfer_last      = 1'b0;
        cap_idx        = cap_cnt[IW-1:0];
        busy           = (state != IDLE);
        result.m_valid = 1'b0;
        result.m_name  = '0;
        result.m_value = '0;
        result.m_index = '0;
        result.m_last  = 1'b0;

        case (state)
            IDLE: begin
                if (done && armed) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                rd_en    = (issue_cnt < CW'(k));
                // The oldest pipe stage marks the cycle the accelerator data is valid.
                cap_hit  = strobe_pipe[readLatency-1];
                cap_last = cap_hit && (cap_cnt == CW'(k - 1));
                if (cap_last) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                result.m_valid = 1'b1;
                result.m_name  = buf_name[ptr];
                result.m_value = buf_value[ptr];
                result.m_index = ptr;
                result.m_last  = (ptr == IW'(k - 1));
                xfer           = result.m_ready;
                xfer_last      = xfer && (ptr == IW'(k - 1));
                if (xfer_last) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            armed       <= 1'b1;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            ptr         <= '0;
            strobe_pipe <= '0;
            complete    <= 1'b0;
            for (int unsigned i = 0; i < k; i++) begin
                buf_name[i]  <= '0;
                buf_value[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            complete <= xfer_last;

            strobe_pipe[0] <= rd_en;
            for (int unsigned i = 1; i < readLatency; i++) begin
                strobe_pipe[i] <= strobe_pipe[i-1];
            end

            // armed re-arms only once done has been seen low while idle.
            if (state == IDLE) begin
                issue_cnt <= '0;
                cap_cnt   <= '0;
                if (done && armed) begin
                    armed <= 1'b0;
                end else if (!done) begin
                    armed <= 1'b1;
                end
            end

            if (rd_en) begin
                issue_cnt <= issue_cnt + CW'(1);
            end

            if (cap_hit) begin
                buf_name[cap_idx]  <= dataNameIn;
                buf_value[cap_idx] <= dataValueIn;
                cap_cnt            <= cap_cnt + CW'(1);
            end

            if (xfer) begin
                ptr <= xfer_last ? '0 : ptr + IW'(1);
            end
        end
    end
endmodule
